// File: rtl/euler_pkg.sv
// euler_pkg: shared types and constants for the Euler compute cores.
//   fib_mode_t  : term-selection mode (even / odd / all / all-reserved)
//   fib_state_t : fib_sum_accel controller states
//   FIB_SEED_A/B: first two terms of the walked sequence (1, 2)
//   mode_selects: true when a term with the given parity belongs to the mode
package euler_pkg;

  typedef enum logic [1:0] {
    MODE_EVEN = 2'd0,
    MODE_ODD  = 2'd1,
    MODE_ALL  = 2'd2,
    MODE_RSVD = 2'd3
  } fib_mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } fib_state_t;

  localparam int FIB_SEED_A = 1;
  localparam int FIB_SEED_B = 2;

  // The reserved mode behaves like MODE_ALL.
  function automatic logic mode_selects(input fib_mode_t m, input logic odd);
    case (m)
      MODE_EVEN: return !odd;
      MODE_ODD:  return odd;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/fib_step.sv
// fib_step: registered Fibonacci pair (a, b).
//   clk      in   clock, rising edge
//   reset    in   synchronous, active-high; reloads the seeds
//   load     in   reload a=FIB_SEED_A, b=FIB_SEED_B
//   advance  in   a <= b, b <= a + b
//   term     out  current term a
//   carry    out  carry-out of the a+b that formed b, i.e. the pending next
//                 term does not fit in W bits and term is the last valid one
module fib_step
  import euler_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         advance,
  output logic [W-1:0] term,
  output logic         carry
);

  logic [W-1:0] b;
  logic [W:0]   next_sum;

  assign next_sum = {1'b0, term} + {1'b0, b};

  always_ff @(posedge clk) begin
    if (reset || load) begin
      term  <= W'(FIB_SEED_A);
      b     <= W'(FIB_SEED_B);
      carry <= 1'b0;
    end else if (advance) begin
      term  <= b;
      b     <= next_sum[W-1:0];
      carry <= next_sum[W];
    end
  end

endmodule

// File: rtl/fib_sum_accel.sv
// fib_sum_accel: walks 1,2,3,5,8,... one term per enabled clock up to an
// inclusive limit and sums the terms chosen by mode, saturating at all-ones.
//   clk, reset      clock; synchronous active-high reset
//   enable          clock-enable, low freezes every register
//   start           request, accepted in IDLE/DONE when enable=1
//   max_value, mode limit and selection, latched on accepted start
//   busy            high in RUN
//   results_valid   high in DONE until the next accepted start or reset
//   results         final (saturated) sum, updated on entry to DONE
//   overflow        set when the sum saturated during the run
//   term_count      number of selected terms (saturating); only present
//                   when FIB_SUM_TERM_COUNT_EN is defined
//
// state  | meaning
// S_IDLE | after reset, waiting for start
// S_RUN  | walking terms, accumulating selected ones
// S_DONE | result presented, waiting for start
module fib_sum_accel
  import euler_pkg::*;
#(
  parameter int W     = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic [W-1:0]     max_value,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             results_valid,
  output logic [W-1:0]     results,
  output logic             overflow
`ifdef FIB_SUM_TERM_COUNT_EN
  ,
  output logic [CNT_W-1:0] term_count
`endif
);

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  fib_state_t   state;
  fib_mode_t    mode_q;
  logic [W-1:0] limit;
  logic [W-1:0] acc;
  logic         ovf;

  logic [W-1:0] term;
  logic         carry;
  logic         load;
  logic         advance;
  logic         stop_limit;
  logic         sel;
  logic [W:0]   add_full;
  logic [W-1:0] acc_next;
  logic         ovf_next;

  assign load       = enable && start && (state != S_RUN);
  assign stop_limit = term > limit;
  // No advance on the last representable term: the run ends there.
  assign advance    = enable && (state == S_RUN) && !stop_limit && !carry;

  assign sel      = mode_selects(mode_q, term[0]);
  assign add_full = {1'b0, acc} + {1'b0, term};
  assign acc_next = !sel ? acc : (add_full[W] ? '1 : add_full[W-1:0]);
  assign ovf_next = ovf | (sel & add_full[W]);

`ifdef FIB_SUM_TERM_COUNT_EN
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  assign cnt_next = (sel && (cnt != '1)) ? cnt + 1'b1 : cnt;
`endif

  fib_step #(.W(W)) u_step (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .advance (advance),
    .term    (term),
    .carry   (carry)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      mode_q        <= MODE_EVEN;
      limit         <= '0;
      acc           <= '0;
      ovf           <= 1'b0;
      busy          <= 1'b0;
      results_valid <= 1'b0;
      results       <= '0;
      overflow      <= 1'b0;
`ifdef FIB_SUM_TERM_COUNT_EN
      cnt           <= '0;
      term_count    <= '0;
`endif
    end else if (enable) begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state         <= S_RUN;
            busy          <= 1'b1;
            results_valid <= 1'b0;
            acc           <= '0;
            ovf           <= 1'b0;
            limit         <= max_value;
            mode_q        <= fib_mode_t'(mode);
`ifdef FIB_SUM_TERM_COUNT_EN
            cnt           <= '0;
`endif
          end
        end
        S_RUN: begin
          if (stop_limit) begin
            state         <= S_DONE;
            busy          <= 1'b0;
            results_valid <= 1'b1;
            results       <= acc;
            overflow      <= ovf;
`ifdef FIB_SUM_TERM_COUNT_EN
            term_count    <= cnt;
`endif
          end else begin
            acc <= acc_next;
            ovf <= ovf_next;
`ifdef FIB_SUM_TERM_COUNT_EN
            cnt <= cnt_next;
`endif
            // Term is counted, then the run ends: the next one is unrepresentable.
            if (carry) begin
              state         <= S_DONE;
              busy          <= 1'b0;
              results_valid <= 1'b1;
              results       <= acc_next;
              overflow      <= ovf_next;
`ifdef FIB_SUM_TERM_COUNT_EN
              term_count    <= cnt_next;
`endif
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fib_sum_accel.sv
module tb_fib_sum_accel;

  localparam int W     = 32;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             start;
  logic [W-1:0]     max_value;
  logic [1:0]       mode;
  logic             busy;
  logic             results_valid;
  logic [W-1:0]     results;
  logic             overflow;
`ifdef FIB_SUM_TERM_COUNT_EN
  logic [CNT_W-1:0] term_count;
`endif

  fib_sum_accel #(.W(W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .start         (start),
    .max_value     (max_value),
    .mode          (mode),
    .busy          (busy),
    .results_valid (results_valid),
    .results       (results),
    .overflow      (overflow)
`ifdef FIB_SUM_TERM_COUNT_EN
    ,
    .term_count    (term_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    int           lat;
    int           cnt;
  } exp_t;

  exp_t q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   done_cnt  = 0;
  bit   armed     = 0;
  int   lat_cnt   = 0;
  bit   prev_valid = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: walk the sequence with wide integers, sum selected terms,
  // clip to W bits. Latency counts enabled edges from the accepting edge.
  function automatic exp_t model(input logic [W-1:0] maxv, input int m);
    longint unsigned a = 1, b = 2, t, sum = 0;
    longint unsigned lim = maxv;
    longint unsigned top = 64'hFFFF_FFFF;
    int terms = 0, cnt = 0;
    exp_t e;
    e.lat = 0;
    while (1) begin
      if (a > lim) begin
        e.lat = terms + 2;
        break;
      end
      if (m >= 2 || int'(a % 2) == m) begin
        sum += a;
        cnt++;
      end
      terms++;
      if (b > top) begin
        e.lat = terms + 1;
        break;
      end
      t = a + b;
      a = b;
      b = t;
    end
    e.ovf = (sum > top);
    e.res = e.ovf ? '1 : sum[31:0];
    e.cnt = (cnt > 255) ? 255 : cnt;
    return e;
  endfunction

  // Monitor: counts enabled edges of the active run and scores each result.
  always @(posedge clk) begin
    exp_t e;
    if (reset) armed = 0;
    else if (enable) begin
      if (start && !armed) begin
        armed   = 1;
        lat_cnt = 1;
      end else if (armed) begin
        lat_cnt++;
      end
    end
    #1;
    if (results_valid && !prev_valid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual=1 required=0");
      end else begin
        e = q.pop_front();
        check("results", results, e.res);
        check("overflow", overflow, e.ovf);
        check("latency", lat_cnt, e.lat);
`ifdef FIB_SUM_TERM_COUNT_EN
        check("term_count", term_count, e.cnt);
`endif
        done_cnt++;
      end
      armed = 0;
    end
    prev_valid = results_valid;
  end

  // en_mode: 0 steady high, 1 alternating, 2 random
  task automatic run_job(input logic [W-1:0] maxv, input int m, input int en_mode,
                         input bit mid_start);
    exp_t e;
    int   target, cycles;
    e = model(maxv, m);
    q.push_back(e);
    target = done_cnt + 1;
    @(negedge clk);
    max_value = maxv;
    mode      = 2'(m);
    start     = 1'b1;
    enable    = 1'b1;
    @(negedge clk);
    check("valid_drop_on_start", results_valid, 0);
    check("busy_on_start", busy, 1);
    start     = 1'b0;
    max_value = $urandom;
    mode      = 2'($urandom_range(0, 3));
    cycles    = 0;
    while (done_cnt < target && cycles < 3000) begin
      case (en_mode)
        1:       enable = ~enable;
        2:       enable = 1'($urandom);
        default: enable = 1'b1;
      endcase
      start = (mid_start && cycles == 5);
      @(negedge clk);
      cycles++;
    end
    enable = 1'b1;
    start  = 1'b0;
    if (done_cnt < target) begin
      checks++;
      failures++;
      $display("FAIL timeout actual=%0d required=%0d", done_cnt, target);
      q.delete();
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, results_valid, 0);
    check({tag, "_results"}, results, 0);
    check({tag, "_overflow"}, overflow, 0);
`ifdef FIB_SUM_TERM_COUNT_EN
    check({tag, "_term_count"}, term_count, 0);
`endif
  endtask

  initial begin
    exp_t e;
    reset     = 1'b1;
    enable    = 1'b1;
    start     = 1'b0;
    max_value = '0;
    mode      = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    @(negedge clk);
    reset = 1'b0;

    run_job(32'd4000000, 0, 0, 0);
    e = model(32'd4000000, 0);
    repeat (3) @(negedge clk);
    check("valid_hold", results_valid, 1);
    check("results_hold", results, e.res);

    run_job(32'd10, 2, 0, 0);
    run_job(32'd10, 1, 0, 0);
    run_job(32'd0, 0, 0, 0);
    run_job(32'd0, 3, 0, 0);
    run_job(32'd1, 0, 0, 0);
    run_job(32'd1, 1, 0, 0);
    run_job(32'hFFFF_FFFF, 2, 0, 0);
    run_job(32'd4000000, 0, 1, 1);

    // Reset ten cycles into a run: cleared outputs, no result appears.
    @(negedge clk);
    max_value = 32'd4000000;
    mode      = 2'd0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_cleared("midrun_reset");
    @(negedge clk);
    reset = 1'b0;
    run_job(32'd4000000, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] mv;
      case ($urandom_range(0, 2))
        0:       mv = $urandom_range(0, 200);
        1:       mv = $urandom_range(0, 5000000);
        default: mv = $urandom;
      endcase
      run_job(mv, $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=%0d required=%0d", done_cnt, -1);
    $fatal(1, "watchdog expired");
  end

endmodule
